// File: rtl/ft245_sync_tx.sv
// ft245_sync_tx: transmit stage of the FT2232H FT245 synchronous-mode port.
// Bytes from the sample producer are queued in a small FIFO and written to
// the FT2232H with TXE#/WR#. The bus is yielded whenever the RX controller
// owns it, and a one-cycle turnaround precedes every bus drive.
// Optional feature macro: FT_TX_SIWU_EN (send-immediate pulse after idle).
module ft245_sync_tx #(
    parameter int ADDR_W    = 4,
    parameter int SIWU_IDLE = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_en_i,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    input  logic              rx_busy_i,
    input  logic              txe_i,
    output logic              wr_o,
    output logic [7:0]        data_o,
    output logic              data_t_o,
    output logic              siwu_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              full_r;
    logic              overflow_r;
    state_t            state_r;
    logic              wr_r;
    logic              data_t_r;
    logic [7:0]        data_r;

    logic              push_s;
    logic              pop_s;
    logic [ADDR_W:0]   count_next_s;
    logic [ADDR_W-1:0] rd_ptr_next_s;
    logic              empty_after_pop_s;
    logic [7:0]        head_next_s;

    // Handshake decode, next occupancy and the byte that will sit at the head
    // after this edge (bypassing the write when the FIFO would otherwise be empty).
    always_comb begin
        push_s            = wr_en_i && !full_r;
        // The FT2232H takes a byte only when WR# and TXE# are both low and the
        // RX side does not own the bus at that edge.
        pop_s             = !wr_r && !txe_i && !rx_busy_i;
        count_next_s      = count_r + {{ADDR_W{1'b0}}, push_s} - {{ADDR_W{1'b0}}, pop_s};
        rd_ptr_next_s     = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        empty_after_pop_s = (count_r == {{ADDR_W{1'b0}}, pop_s});
        if (push_s && empty_after_pop_s) begin
            head_next_s = wr_data_i;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage: written on every accepted push, never cleared.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == DEPTH_C);
            if (wr_en_i && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Bus ownership FSM: IDLE -> TURN (drive, WR# high) -> SEND (stream bytes).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            wr_r     <= 1'b1;
            data_t_r <= 1'b0;
            data_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_r <= 1'b1;
                    if (!rx_busy_i && (count_r != CNT_ZERO)) begin
                        state_r  <= ST_TURN;
                        data_t_r <= 1'b1;
                        data_r   <= head_next_s;
                    end else begin
                        data_t_r <= 1'b0;
                        data_r   <= 8'h00;
                    end
                end
                ST_TURN: begin
                    if (!rx_busy_i) begin
                        // FIFO is non-empty here: nothing can pop while WR# is high.
                        state_r  <= ST_SEND;
                        wr_r     <= txe_i;
                        data_t_r <= 1'b1;
                        data_r   <= head_next_s;
                    end else begin
                        state_r  <= ST_IDLE;
                        wr_r     <= 1'b1;
                        data_t_r <= 1'b0;
                        data_r   <= 8'h00;
                    end
                end
                ST_SEND: begin
                    if (rx_busy_i || (pop_s && (count_next_s == CNT_ZERO))) begin
                        state_r  <= ST_IDLE;
                        wr_r     <= 1'b1;
                        data_t_r <= 1'b0;
                        data_r   <= 8'h00;
                    end else begin
                        // A byte refused by TXE# stays at the head and is retried.
                        wr_r     <= !(!txe_i && (count_next_s != CNT_ZERO));
                        data_t_r <= 1'b1;
                        data_r   <= head_next_s;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wr_r     <= 1'b1;
                    data_t_r <= 1'b0;
                    data_r   <= 8'h00;
                end
            endcase
        end
    end

`ifdef FT_TX_SIWU_EN
    localparam int IDLE_W = (SIWU_IDLE > 1) ? $clog2(SIWU_IDLE + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SIWU_IDLE - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    logic [IDLE_W-1:0] idle_cnt_r;
    logic              sent_r;
    logic              siwu_r;

    // Send-immediate: after data went out and the port has sat idle and empty
    // for SIWU_IDLE cycles, pulse SIWU# low once to flush the chip's buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt_r <= '0;
            sent_r     <= 1'b0;
            siwu_r     <= 1'b1;
        end else if (pop_s) begin
            idle_cnt_r <= '0;
            sent_r     <= 1'b1;
            siwu_r     <= 1'b1;
        end else if ((state_r == ST_IDLE) && (count_r == CNT_ZERO) && sent_r) begin
            if (idle_cnt_r == IDLE_LAST) begin
                idle_cnt_r <= '0;
                sent_r     <= 1'b0;
                siwu_r     <= 1'b0;
            end else begin
                idle_cnt_r <= idle_cnt_r + IDLE_ONE;
                siwu_r     <= 1'b1;
            end
        end else begin
            idle_cnt_r <= '0;
            siwu_r     <= 1'b1;
        end
    end

    assign siwu_o = siwu_r;
`else
    assign siwu_o = 1'b1;
`endif

    assign full_o     = full_r;
    assign count_o    = count_r;
    assign overflow_o = overflow_r;
    assign wr_o       = wr_r;
    assign data_t_o   = data_t_r;
    assign data_o     = data_r;

endmodule

// File: tb/tb_ft245_sync_tx.sv
// Testbench for ft245_sync_tx: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a byte-queue model of
// the FIFO and the FT2232H accept rule.
module tb_ft245_sync_tx;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] wr_data_i;
    logic       wr_en_i;
    logic       full_o;
    logic [4:0] count_o;
    logic       overflow_o;
    logic       rx_busy_i;
    logic       txe_i;
    logic       wr_o;
    logic [7:0] data_o;
    logic       data_t_o;
    logic       siwu_o;

    always #5 clk_i = ~clk_i;

    ft245_sync_tx #(.ADDR_W(4), .SIWU_IDLE(255)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_data_i  (wr_data_i),
        .wr_en_i    (wr_en_i),
        .full_o     (full_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .rx_busy_i  (rx_busy_i),
        .txe_i      (txe_i),
        .wr_o       (wr_o),
        .data_o     (data_o),
        .data_t_o   (data_t_o),
        .siwu_o     (siwu_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bytes accepted but not yet delivered, sticky overflow.
    logic [7:0] q[$];
    logic       ovf_m = 1'b0;
    int         delivered = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] din;
        logic       txe;
        logic       rx;
        logic       exp_wr;
        logic       exp_dt;
        logic [7:0] exp_data;
        logic [4:0] exp_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rst, input logic en, input logic [7:0] din,
                          input logic txe, input logic rx);
        rst_i     = rst;
        wr_en_i   = en;
        wr_data_i = din;
        txe_i     = txe;
        rx_busy_i = rx;
    endtask

    // One clock: capture pre-edge state, advance, update model and compare.
    task automatic step();
        logic       p_wr, p_txe, p_rx, p_en, p_rst;
        logic [7:0] p_data, p_din;
        int         p_size;
        bit         pop_m;
        p_wr   = wr_o;
        p_txe  = txe_i;
        p_rx   = rx_busy_i;
        p_en   = wr_en_i;
        p_rst  = rst_i;
        p_data = data_o;
        p_din  = wr_data_i;
        p_size = q.size();
        @(posedge clk_i);
        #1;
        if (p_rst) begin
            q.delete();
            ovf_m = 1'b0;
            chk("rst_wr", wr_o, 1);
            chk("rst_dt", data_t_o, 0);
            chk("rst_count", count_o, 0);
            chk("rst_ovf", overflow_o, 0);
            chk("rst_full", full_o, 0);
        end else begin
            pop_m = (p_wr === 1'b0) && !p_txe && !p_rx;
            if (pop_m) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_when_empty: byte %0h accepted, model queue empty", p_data);
                end else begin
                    chk("pop_data", p_data, q.pop_front());
                    delivered++;
                end
            end
            if (p_en) begin
                if (p_size < 16) q.push_back(p_din);
                else ovf_m = 1'b1;
            end
            chk("count", count_o, q.size());
            chk("full", full_o, (q.size() == 16));
            chk("overflow", overflow_o, ovf_m);
            if (p_rx) begin
                chk("rx_yield_wr", wr_o, 1);
                chk("rx_yield_dt", data_t_o, 0);
            end
            if ((p_wr === 1'b0) && !pop_m && !p_rx) chk("hold_data", data_o, p_data);
        end
        if (wr_o == 1'b0) chk("wr_needs_dt", data_t_o, 1);
        if (data_t_o == 1'b0) chk("undriven_data", data_o, 0);
`ifndef FT_TX_SIWU_EN
        chk("siwu_const", siwu_o, 1);
`endif
    endtask

    // Let the FIFO empty with TXE# low and no RX traffic, within a cycle budget.
    task automatic drain(input int budget);
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < budget; k++) begin
            if ((q.size() == 0) && (count_o == 5'd0) && wr_o && !data_t_o) break;
            step();
        end
        chk("drain_count", count_o, 0);
        chk("drain_model", q.size(), 0);
        chk("drain_wr", wr_o, 1);
        chk("drain_dt", data_t_o, 0);
    endtask

    initial begin
        int d0;
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset, then three pushes streamed out back-to-back.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0};
        tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1};
        tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 5'd2};
        tbl[3] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 5'd3};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 5'd2};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 5'd1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0};
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].rst, tbl[i].en, tbl[i].din, tbl[i].txe, tbl[i].rx);
            step();
            chk($sformatf("tbl%0d_wr", i), wr_o, tbl[i].exp_wr);
            chk($sformatf("tbl%0d_dt", i), data_t_o, tbl[i].exp_dt);
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].exp_data);
            chk($sformatf("tbl%0d_count", i), count_o, tbl[i].exp_cnt);
        end

        // TXE# high for 4 cycles while the second byte is on the bus.
        d0 = delivered;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
            step();
        end
        chk("txe_pre_data", data_o, 8'hA2);
        chk("txe_pre_wr", wr_o, 0);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, (i == 0), 8'hA5, 1'b1, 1'b0);
            step();
            chk("txe_hold_wr", wr_o, 1);
            chk("txe_hold_data", data_o, 8'hA2);
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("txe_retry_wr", wr_o, 0);
        chk("txe_retry_data", data_o, 8'hA2);
        drain(50);
        chk("txe_delivered", delivered - d0, 5);

        // RX controller takes the bus mid-burst.
        d0 = delivered;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 8'hB1 + 8'(i), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            step();
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("rx_turn_dt", data_t_o, 1);
        chk("rx_turn_wr", wr_o, 1);
        step();
        chk("rx_resume_wr", wr_o, 0);
        chk("rx_resume_data", data_o, 8'hB2);
        drain(50);
        chk("rx_delivered", delivered - d0, 4);

        // Fill with TXE# high, overflow on the 17th push, drain across the wrap.
        d0 = delivered;
        for (int i = 0; i < 17; i++) begin
            set_in(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
            step();
            if (i == 15) chk("fill_full", full_o, 1);
        end
        chk("fill_ovf", overflow_o, 1);
        chk("fill_count", count_o, 16);
        drain(100);
        chk("fill_delivered", delivered - d0, 16);
        chk("fill_ovf_sticky", overflow_o, 1);

        // Reset during an active burst.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0);
            step();
        end
        chk("burst_active", wr_o, 0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("post_rst_count", count_o, 0);
        chk("post_rst_wr", wr_o, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)),
                   8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            step();
        end
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
